// File: rtl/l2t_sii_pkg.sv
// -----------------------------------------------------------------------------
// l2t_sii_pkg
// Shared definitions for the SII->L2T inbound request receiver:
//   - request command encodings and their position inside header word H0
//   - data-word counts per command and the DATA-state counter load values
//   - receiver FSM state type
//   - bit indices of the sticky error vector
// -----------------------------------------------------------------------------
package l2t_sii_pkg;

  // Command field lives in H0[31:30]
  localparam int H0_CMD_MSB = 31;
  localparam int H0_CMD_LSB = 30;

  localparam logic [1:0] CMD_RD   = 2'b00;
  localparam logic [1:0] CMD_WRI  = 2'b01;
  localparam logic [1:0] CMD_WR8  = 2'b10;
  localparam logic [1:0] CMD_RSVD = 2'b11;

  localparam int WRI_WORDS = 16;
  localparam int WR8_WORDS = 2;

  // The DATA counter counts down to zero, so it is loaded with words-1
  localparam logic [3:0] WRI_CNT_INIT = 4'(WRI_WORDS - 1);
  localparam logic [3:0] WR8_CNT_INIT = 4'(WR8_WORDS - 1);

  // err_sticky = {overflow, protocol, bad_cmd}
  localparam int ERR_OVERFLOW = 2;
  localparam int ERR_PROTOCOL = 1;
  localparam int ERR_BAD_CMD  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR0 = 2'd1,
    ST_HDR1 = 2'd2,
    ST_DATA = 2'd3
  } rcv_state_e;

  // Counter load value for commands that carry data (RD/RSVD never reach DATA)
  function automatic logic [3:0] data_cnt_init(input logic [1:0] cmd);
    logic [3:0] cnt;
    case (cmd)
      CMD_WRI: cnt = WRI_CNT_INIT;
      CMD_WR8: cnt = WR8_CNT_INIT;
      default: cnt = 4'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/l2t_sii_sync_fifo.sv
// -----------------------------------------------------------------------------
// l2t_sii_sync_fifo
// Single-clock FIFO with extended (log2(DEPTH)+1 bit) pointers.
//   clk, rst_l      : clock, asynchronous active-low reset (pointers only)
//   push, push_data : write request; dropped when full unless a pop frees
//                     the slot in the same cycle
//   pop             : read request; ignored when empty
//   full, empty     : status from the pointer compare
//   head            : oldest entry, forced to zero while empty so the
//                     output is clean after reset
// -----------------------------------------------------------------------------
module l2t_sii_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_en_s;
  logic             pop_en_s;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];

  // Qualify requests and advance the pointers
  always_comb begin
    pop_en_s  = pop && !empty;
    // A pop this cycle vacates the slot a push into a full FIFO would need
    push_en_s = push && (!full || pop_en_s);
    if (push_en_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_en_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/l2t_sii_iq_rcv.sv
// -----------------------------------------------------------------------------
// l2t_sii_iq_rcv
// L2-tag-side receiver for the SII->L2T request channel. Deserialises the
// vld/H0/H1/data stream, queues headers in the IQ and write data in the WIB,
// and returns IQ/WIB credits to SII.
//   iol2clk, rst_l            : clock, asynchronous active-low reset
//   sii_l2t_req_vld/req       : packet start pulse and 32-bit word stream
//   l2t_sii_iq_dequeue        : one-cycle credit per freed IQ entry
//   l2t_sii_wib_dequeue       : one-cycle credit per drained 64 B WRI block
//   iq_vld/iq_hdr/iq_pop      : IQ head {H0,H1} toward the L2 pipe
//   wib_vld/wib_data/wib_pop  : WIB head word toward the L2 pipe
//   err_sticky                : {overflow, protocol, bad_cmd}
// -----------------------------------------------------------------------------
module l2t_sii_iq_rcv
  import l2t_sii_pkg::*;
#(
  parameter int IQ_DEPTH  = 4,
  parameter int WIB_DEPTH = 32
) (
  input  logic        iol2clk,
  input  logic        rst_l,
  input  logic        sii_l2t_req_vld,
  input  logic [31:0] sii_l2t_req,
  output logic        l2t_sii_iq_dequeue,
  output logic        l2t_sii_wib_dequeue,
  output logic        iq_vld,
  output logic [63:0] iq_hdr,
  input  logic        iq_pop,
  output logic        wib_vld,
  output logic [31:0] wib_data,
  input  logic        wib_pop,
  output logic [2:0]  err_sticky
);

  rcv_state_e  state_q, state_d;
  logic [31:0] h0_q, h0_d;
  logic [31:0] h1_q, h1_d;
  logic [3:0]  word_cnt_q, word_cnt_d;
  logic        is_wri_q, is_wri_d;
  logic [2:0]  err_q, err_d;
  logic        iq_deq_q, iq_deq_d;
  logic        wib_deq_q, wib_deq_d;
  logic [2:0]  owed_q, owed_d;
  logic [3:0]  wri_rd_cnt_q, wri_rd_cnt_d;

  logic [1:0]  cmd_s;
  logic        iq_push_s;
  logic [63:0] iq_push_data_s;
  logic        wib_push_s;
  logic [32:0] wib_push_data_s;
  logic        rsvd_hit_s;
  logic        iq_full_s, iq_empty_s;
  logic [63:0] iq_head_s;
  logic        wib_full_s, wib_empty_s;
  logic [32:0] wib_head_s;
  logic        iq_pop_ok_s, wib_pop_ok_s;
  logic [3:0]  credit_total_s;

  assign cmd_s        = h0_q[H0_CMD_MSB:H0_CMD_LSB];
  assign iq_pop_ok_s  = iq_pop && !iq_empty_s;
  assign wib_pop_ok_s = wib_pop && !wib_empty_s;

  // Receive FSM: header capture, data counting, IQ/WIB write requests
  always_comb begin
    state_d         = state_q;
    h0_d            = h0_q;
    h1_d            = h1_q;
    word_cnt_d      = word_cnt_q;
    is_wri_d        = is_wri_q;
    iq_push_s       = 1'b0;
    iq_push_data_s  = {h0_q, h1_q};
    wib_push_s      = 1'b0;
    wib_push_data_s = {is_wri_q, sii_l2t_req};
    rsvd_hit_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sii_l2t_req_vld) begin
          state_d = ST_HDR0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR0: begin
        h0_d    = sii_l2t_req;
        state_d = ST_HDR1;
      end
      ST_HDR1: begin
        h1_d = sii_l2t_req;
        case (cmd_s)
          CMD_RD: begin
            // No data follows, so the header is complete now
            iq_push_s      = 1'b1;
            iq_push_data_s = {h0_q, sii_l2t_req};
            state_d        = ST_IDLE;
          end
          CMD_WRI, CMD_WR8: begin
            word_cnt_d = data_cnt_init(cmd_s);
            is_wri_d   = (cmd_s == CMD_WRI);
            state_d    = ST_DATA;
          end
          default: begin
            rsvd_hit_s = 1'b1;
            state_d    = ST_IDLE;
          end
        endcase
      end
      ST_DATA: begin
        wib_push_s = 1'b1;
        if (word_cnt_q == 4'd0) begin
          // Header enters the IQ only with the last word, so the pipe never
          // sees a write whose data is still arriving
          iq_push_s = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          word_cnt_d = word_cnt_q - 4'd1;
          state_d    = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky error accumulation
  always_comb begin
    err_d = err_q;
    if (rsvd_hit_s) begin
      err_d[ERR_BAD_CMD] = 1'b1;
    end else begin
      err_d[ERR_BAD_CMD] = err_q[ERR_BAD_CMD];
    end
    if ((sii_l2t_req_vld && (state_q != ST_IDLE)) ||
        (iq_pop && iq_empty_s) || (wib_pop && wib_empty_s)) begin
      err_d[ERR_PROTOCOL] = 1'b1;
    end else begin
      err_d[ERR_PROTOCOL] = err_q[ERR_PROTOCOL];
    end
    if ((iq_push_s && iq_full_s && !iq_pop_ok_s) ||
        (wib_push_s && wib_full_s && !wib_pop_ok_s)) begin
      err_d[ERR_OVERFLOW] = 1'b1;
    end else begin
      err_d[ERR_OVERFLOW] = err_q[ERR_OVERFLOW];
    end
  end

  // IQ credit return. A dropped reserved packet and a pop can land in the
  // same cycle; the extra credit is owed and paid in a following cycle so
  // SII never loses one.
  always_comb begin
    credit_total_s = {1'b0, owed_q} + {3'b000, iq_pop_ok_s} + {3'b000, rsvd_hit_s};
    if (credit_total_s != 4'd0) begin
      iq_deq_d = 1'b1;
      owed_d   = 3'(credit_total_s - 4'd1);
    end else begin
      iq_deq_d = 1'b0;
      owed_d   = 3'd0;
    end
  end

  // WIB credit return: one pulse per 16 WRI words consumed
  always_comb begin
    if (wib_pop_ok_s && wib_head_s[32]) begin
      wri_rd_cnt_d = wri_rd_cnt_q + 4'd1;
      wib_deq_d    = (wri_rd_cnt_q == 4'd15);
    end else begin
      wri_rd_cnt_d = wri_rd_cnt_q;
      wib_deq_d    = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= ST_IDLE;
      h0_q         <= 32'd0;
      h1_q         <= 32'd0;
      word_cnt_q   <= 4'd0;
      is_wri_q     <= 1'b0;
      err_q        <= 3'd0;
      iq_deq_q     <= 1'b0;
      wib_deq_q    <= 1'b0;
      owed_q       <= 3'd0;
      wri_rd_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      h0_q         <= h0_d;
      h1_q         <= h1_d;
      word_cnt_q   <= word_cnt_d;
      is_wri_q     <= is_wri_d;
      err_q        <= err_d;
      iq_deq_q     <= iq_deq_d;
      wib_deq_q    <= wib_deq_d;
      owed_q       <= owed_d;
      wri_rd_cnt_q <= wri_rd_cnt_d;
    end
  end

  l2t_sii_sync_fifo #(
    .WIDTH (64),
    .DEPTH (IQ_DEPTH)
  ) u_iq (
    .clk       (iol2clk),
    .rst_l     (rst_l),
    .push      (iq_push_s),
    .push_data (iq_push_data_s),
    .pop       (iq_pop),
    .full      (iq_full_s),
    .empty     (iq_empty_s),
    .head      (iq_head_s)
  );

  l2t_sii_sync_fifo #(
    .WIDTH (33),
    .DEPTH (WIB_DEPTH)
  ) u_wib (
    .clk       (iol2clk),
    .rst_l     (rst_l),
    .push      (wib_push_s),
    .push_data (wib_push_data_s),
    .pop       (wib_pop),
    .full      (wib_full_s),
    .empty     (wib_empty_s),
    .head      (wib_head_s)
  );

  assign iq_vld              = !iq_empty_s;
  assign iq_hdr              = iq_head_s;
  assign wib_vld             = !wib_empty_s;
  assign wib_data            = wib_head_s[31:0];
  assign l2t_sii_iq_dequeue  = iq_deq_q;
  assign l2t_sii_wib_dequeue = wib_deq_q;
  assign err_sticky          = err_q;

endmodule

// File: tb/tb_l2t_sii_iq_rcv.sv
// -----------------------------------------------------------------------------
// tb_l2t_sii_iq_rcv
// Directed bench for l2t_sii_iq_rcv. Inputs are driven and outputs sampled
// 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_l2t_sii_iq_rcv;

  logic        iol2clk = 1'b0;
  logic        rst_l;
  logic        sii_l2t_req_vld;
  logic [31:0] sii_l2t_req;
  logic        l2t_sii_iq_dequeue;
  logic        l2t_sii_wib_dequeue;
  logic        iq_vld;
  logic [63:0] iq_hdr;
  logic        iq_pop;
  logic        wib_vld;
  logic [31:0] wib_data;
  logic        wib_pop;
  logic [2:0]  err_sticky;

  int checks   = 0;
  int failures = 0;

  logic [31:0] pkt_data [16];
  logic [63:0] exp_hdr  [5];
  bit          early;

  l2t_sii_iq_rcv #(.IQ_DEPTH(4), .WIB_DEPTH(32)) dut (
    .iol2clk             (iol2clk),
    .rst_l               (rst_l),
    .sii_l2t_req_vld     (sii_l2t_req_vld),
    .sii_l2t_req         (sii_l2t_req),
    .l2t_sii_iq_dequeue  (l2t_sii_iq_dequeue),
    .l2t_sii_wib_dequeue (l2t_sii_wib_dequeue),
    .iq_vld              (iq_vld),
    .iq_hdr              (iq_hdr),
    .iq_pop              (iq_pop),
    .wib_vld             (wib_vld),
    .wib_data            (wib_data),
    .wib_pop             (wib_pop),
    .err_sticky          (err_sticky)
  );

  always #5 iol2clk = ~iol2clk;

  task automatic tick();
    @(posedge iol2clk);
    #1;
  endtask

  // vld cycle, H0, H1, then nwords of pkt_data; returns in the cycle after
  // the last driven word. early is set if iq_vld is seen during the data.
  task automatic send_pkt(input logic [31:0] h0, input logic [31:0] h1,
                          input int nwords, input int vld_at,
                          input bit pop_at_h1, output bit iq_early);
    iq_early        = 1'b0;
    sii_l2t_req_vld = 1'b1;
    sii_l2t_req     = 32'd0;
    tick();
    sii_l2t_req_vld = 1'b0;
    sii_l2t_req     = h0;
    tick();
    sii_l2t_req     = h1;
    iq_pop          = pop_at_h1;
    tick();
    iq_pop          = 1'b0;
    for (int i = 0; i < nwords; i++) begin
      sii_l2t_req     = pkt_data[i];
      sii_l2t_req_vld = (i == vld_at);
      if (iq_vld) iq_early = 1'b1;
      tick();
    end
    sii_l2t_req_vld = 1'b0;
    sii_l2t_req     = 32'd0;
  endtask

  // Pops n IQ entries back to back, expecting exp_hdr[first..first+n-1]
  task automatic drain_iq(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      checks++;
      if (iq_vld !== 1'b1 || iq_hdr !== exp_hdr[i]) begin
        failures++;
        $display("FAIL drain_iq[%0d] got vld=%0b hdr=%h exp vld=1 hdr=%h", i, iq_vld, iq_hdr, exp_hdr[i]);
      end
      iq_pop = 1'b1;
      tick();
      checks++;
      if (l2t_sii_iq_dequeue !== 1'b1) begin
        failures++;
        $display("FAIL drain_iq_credit[%0d] got=%0b exp=1", i, l2t_sii_iq_dequeue);
      end
    end
    iq_pop = 1'b0;
    checks++;
    if (iq_vld !== 1'b0) begin
      failures++;
      $display("FAIL drain_iq_empty got=%0b exp=0", iq_vld);
    end
  endtask

  // Pops n WIB words expecting pkt_data order, then checks wib_dequeue
  task automatic drain_wib(input int n, input bit exp_deq);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (wib_vld !== 1'b1 || wib_data !== pkt_data[i] || l2t_sii_wib_dequeue !== 1'b0) begin
        failures++;
        $display("FAIL drain_wib[%0d] got vld=%0b data=%h deq=%0b exp vld=1 data=%h deq=0",
                 i, wib_vld, wib_data, l2t_sii_wib_dequeue, pkt_data[i]);
      end
      wib_pop = 1'b1;
      tick();
    end
    wib_pop = 1'b0;
    checks++;
    if (l2t_sii_wib_dequeue !== exp_deq || wib_vld !== 1'b0) begin
      failures++;
      $display("FAIL drain_wib_deq got deq=%0b vld=%0b exp deq=%0b vld=0", l2t_sii_wib_dequeue, wib_vld, exp_deq);
    end
    tick();
    checks++;
    if (l2t_sii_wib_dequeue !== 1'b0) begin
      failures++;
      $display("FAIL drain_wib_deq_once got=%0b exp=0", l2t_sii_wib_dequeue);
    end
  endtask

  task automatic test_reset();
    rst_l = 1'b0; sii_l2t_req_vld = 1'b0; sii_l2t_req = 32'd0; iq_pop = 1'b0; wib_pop = 1'b0;
    #1;
    checks++;
    if ({iq_vld, iq_hdr, wib_vld, wib_data, l2t_sii_iq_dequeue, l2t_sii_wib_dequeue, err_sticky} !== 101'd0) begin
      failures++;
      $display("FAIL reset_outputs got iq_vld=%0b wib_vld=%0b err=%b exp all 0", iq_vld, wib_vld, err_sticky);
    end
    tick(); tick();
    rst_l = 1'b1;
    tick();
    checks++;
    if ({iq_vld, wib_vld, l2t_sii_iq_dequeue, l2t_sii_wib_dequeue, err_sticky} !== 7'd0) begin
      failures++;
      $display("FAIL reset_release got iq_vld=%0b wib_vld=%0b err=%b exp all 0", iq_vld, wib_vld, err_sticky);
    end
  endtask

  task automatic test_rd();
    send_pkt(32'h0000_0A01, 32'h1234_5678, 0, -1, 1'b0, early);   // now N+3
    checks++;
    if (iq_vld !== 1'b1 || iq_hdr !== 64'h0000_0A01_1234_5678) begin
      failures++;
      $display("FAIL rd_hdr got vld=%0b hdr=%h exp vld=1 hdr=0000_0a01_1234_5678", iq_vld, iq_hdr);
    end
    tick(); tick();                                                // N+5
    iq_pop = 1'b1;
    checks++;
    if (l2t_sii_iq_dequeue !== 1'b0) begin
      failures++;
      $display("FAIL rd_credit_early got=%0b exp=0", l2t_sii_iq_dequeue);
    end
    tick();                                                        // N+6
    iq_pop = 1'b0;
    checks++;
    if (l2t_sii_iq_dequeue !== 1'b1 || iq_vld !== 1'b0) begin
      failures++;
      $display("FAIL rd_credit got deq=%0b vld=%0b exp deq=1 vld=0", l2t_sii_iq_dequeue, iq_vld);
    end
    tick();                                                        // N+7
    checks++;
    if (l2t_sii_iq_dequeue !== 1'b0) begin
      failures++;
      $display("FAIL rd_credit_once got=%0b exp=0", l2t_sii_iq_dequeue);
    end
  endtask

  // Shared by the plain WRI test and the protocol-error test
  task automatic run_wri(input logic [31:0] h0, input int vld_at, input logic [2:0] exp_err);
    for (int i = 0; i < 16; i++) pkt_data[i] = 32'(i);
    exp_hdr[0] = {h0, 32'hCAFE_0001};
    send_pkt(h0, 32'hCAFE_0001, 16, vld_at, 1'b0, early);
    checks++;
    if (early !== 1'b0 || iq_vld !== 1'b1 || iq_hdr !== exp_hdr[0]) begin
      failures++;
      $display("FAIL wri_hdr got early=%0b vld=%0b hdr=%h exp early=0 vld=1 hdr=%h", early, iq_vld, iq_hdr, exp_hdr[0]);
    end
    checks++;
    if (err_sticky !== exp_err) begin
      failures++;
      $display("FAIL wri_err got=%b exp=%b", err_sticky, exp_err);
    end
    drain_wib(16, 1'b1);
    drain_iq(0, 1);
  endtask

  task automatic test_wr8();
    pkt_data[0] = 32'hAAAA_AAAA;
    pkt_data[1] = 32'h5555_5555;
    exp_hdr[0]  = 64'h8000_0C03_0BAD_F00D;
    send_pkt(32'h8000_0C03, 32'h0BAD_F00D, 2, -1, 1'b0, early);
    checks++;
    if (early !== 1'b0 || iq_hdr !== exp_hdr[0] || err_sticky !== 3'b000) begin
      failures++;
      $display("FAIL wr8_hdr got early=%0b hdr=%h err=%b exp early=0 hdr=%h err=000", early, iq_hdr, err_sticky, exp_hdr[0]);
    end
    drain_wib(2, 1'b0);
    drain_iq(0, 1);
  endtask

  task automatic fill_iq(input int n);
    for (int i = 0; i < n; i++) begin
      send_pkt(exp_hdr[i][63:32], exp_hdr[i][31:0], 0, -1, 1'b0, early);
    end
  endtask

  task automatic test_iq_full_pushpop();
    for (int i = 0; i < 5; i++) exp_hdr[i] = {32'h0000_0100 + 32'(i), 32'h1000_0000 + 32'(i)};
    fill_iq(4);
    send_pkt(exp_hdr[4][63:32], exp_hdr[4][31:0], 0, -1, 1'b1, early);
    checks++;
    if (err_sticky !== 3'b000 || iq_hdr !== exp_hdr[1] || l2t_sii_iq_dequeue !== 1'b1) begin
      failures++;
      $display("FAIL full_pushpop got err=%b hdr=%h deq=%0b exp err=000 hdr=%h deq=1", err_sticky, iq_hdr, l2t_sii_iq_dequeue, exp_hdr[1]);
    end
    drain_iq(1, 4);
  endtask

  task automatic test_iq_overflow();
    fill_iq(4);
    checks++;
    if (err_sticky !== 3'b000) begin
      failures++;
      $display("FAIL ovf_pre_err got=%b exp=000", err_sticky);
    end
    send_pkt(32'h0000_0999, 32'h9999_9999, 0, -1, 1'b0, early);
    checks++;
    if (err_sticky !== 3'b100 || iq_hdr !== exp_hdr[0]) begin
      failures++;
      $display("FAIL ovf got err=%b hdr=%h exp err=100 hdr=%h", err_sticky, iq_hdr, exp_hdr[0]);
    end
    drain_iq(0, 4);
  endtask

  task automatic test_reserved();
    send_pkt(32'hC000_0000, 32'h1111_1111, 0, -1, 1'b0, early);   // HDR1 + 1
    checks++;
    if (err_sticky !== 3'b101 || iq_vld !== 1'b0 || l2t_sii_iq_dequeue !== 1'b1) begin
      failures++;
      $display("FAIL rsvd got err=%b vld=%0b deq=%0b exp err=101 vld=0 deq=1", err_sticky, iq_vld, l2t_sii_iq_dequeue);
    end
    tick();
    checks++;
    if (l2t_sii_iq_dequeue !== 1'b0 || iq_vld !== 1'b0 || wib_vld !== 1'b0) begin
      failures++;
      $display("FAIL rsvd_after got deq=%0b iq_vld=%0b wib_vld=%0b exp 0 0 0", l2t_sii_iq_dequeue, iq_vld, wib_vld);
    end
  endtask

  task automatic test_reset_midflight();
    sii_l2t_req_vld = 1'b1;
    tick();
    sii_l2t_req_vld = 1'b0;
    sii_l2t_req = 32'h4000_0D04;
    tick();
    sii_l2t_req = 32'h7777_0000;
    tick();
    for (int i = 0; i < 7; i++) begin
      sii_l2t_req = 32'(i);
      tick();
    end
    sii_l2t_req = 32'd7;
    checks++;
    if (wib_vld !== 1'b1) begin
      failures++;
      $display("FAIL midflight_pre got wib_vld=%0b exp=1", wib_vld);
    end
    rst_l = 1'b0;
    #1;
    checks++;
    if ({iq_vld, iq_hdr, wib_vld, wib_data, l2t_sii_iq_dequeue, l2t_sii_wib_dequeue, err_sticky} !== 101'd0) begin
      failures++;
      $display("FAIL midflight_reset got iq_vld=%0b wib_vld=%0b data=%h err=%b exp all 0", iq_vld, wib_vld, wib_data, err_sticky);
    end
    tick();
    rst_l = 1'b1;
    sii_l2t_req = 32'd0;
    tick();
    exp_hdr[0] = 64'h0000_0E05_2222_3333;
    send_pkt(32'h0000_0E05, 32'h2222_3333, 0, -1, 1'b0, early);
    checks++;
    if (iq_hdr !== exp_hdr[0] || wib_vld !== 1'b0 || err_sticky !== 3'b000) begin
      failures++;
      $display("FAIL midflight_rd got hdr=%h wib_vld=%0b err=%b exp hdr=%h wib_vld=0 err=000", iq_hdr, wib_vld, err_sticky, exp_hdr[0]);
    end
    drain_iq(0, 1);
  endtask

  initial begin
    test_reset();
    test_rd();
    run_wri(32'h4000_0B02, -1, 3'b000);
    test_wr8();
    test_iq_full_pushpop();
    test_iq_overflow();
    test_reserved();
    run_wri(32'h4000_0B03, 5, 3'b111);
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
